// File: rtl/small_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : small_div_pkg
// Purpose  : Shared sizing helpers and the constant long-division digit step
//            used by the small_div stage chain.
// Revision : 1.0 - initial release
// ============================================================================
package small_div_pkg;

  // Width of each half of the packed {quotient, remainder} word from div_step.
  localparam int c_STEP_HALF = 32;

  // Bits needed to hold any remainder of a division by the given divisor.
  function automatic int divider_width(input int divisor);
    return $clog2(divisor);
  endfunction

  // Digit chunk width. The remainder takes R bits of the LUT input and the
  // chunk gets the rest, with a floor of one bit.
  function automatic int chunk_width(input int lut_width, input int div_width);
    return (lut_width - div_width < 1) ? 1 : (lut_width - div_width);
  endfunction

  // Number of chunks needed to cover the dividend, rounding up.
  function automatic int stage_count(input int dividend_width, input int chunk_w);
    return (dividend_width + chunk_w - 1) / chunk_w;
  endfunction

  // One long-division step, evaluated only on elaboration-time constants.
  // Returns {quotient[31:0], remainder[31:0]}.
  function automatic logic [2*c_STEP_HALF-1:0] div_step(input int unsigned x,
                                                        input int unsigned divisor);
    logic [c_STEP_HALF-1:0] q;
    logic [c_STEP_HALF-1:0] r;
    q = x / divisor;
    r = x % divisor;
    return {q, r};
  endfunction

endpackage
`default_nettype wire

// File: rtl/small_div_stage.sv
`default_nettype none
// ============================================================================
// Module   : small_div_stage
// Purpose  : One long-division digit step: {remainder_in, chunk} -> quotient
//            digit and remainder_out, realised as a constant lookup table.
// Revision : 1.0 - initial release
// ============================================================================
module small_div_stage
  import small_div_pkg::*;
#(
  parameter int DIVIDER_VALUE = 5,
  parameter int DIVIDER_WIDTH = 3,
  parameter int CHUNK_WIDTH   = 3
) (
  input  logic [DIVIDER_WIDTH-1:0] i_rem,
  input  logic [CHUNK_WIDTH-1:0]   i_chunk,
  output logic [CHUNK_WIDTH-1:0]   o_quot,
  output logic [DIVIDER_WIDTH-1:0] o_rem
);

  localparam int c_X_WIDTH = DIVIDER_WIDTH + CHUNK_WIDTH;
  localparam int c_ENTRIES = 2 ** c_X_WIDTH;

  logic [c_X_WIDTH-1:0] w_x;
  logic [c_X_WIDTH-1:0] w_rom [c_ENTRIES];

  // Table entries whose remainder field is >= divisor can never be addressed
  // (the incoming remainder is always < divisor); their truncated quotient
  // is therefore harmless.
  for (genvar g = 0; g < c_ENTRIES; g++) begin : g_rom
    localparam logic [2*c_STEP_HALF-1:0] c_STEP = div_step(g, DIVIDER_VALUE);
    assign w_rom[g] = {c_STEP[c_STEP_HALF +: CHUNK_WIDTH], c_STEP[0 +: DIVIDER_WIDTH]};
  end

  assign w_x             = {i_rem, i_chunk};
  assign {o_quot, o_rem} = w_rom[w_x];

endmodule
`default_nettype wire

// File: rtl/small_div.sv
`default_nettype none
// ============================================================================
// Module   : small_div
// Purpose  : Unsigned divide-by-constant via a combinational chain of small
//            digit lookup stages, with optional input and output registers.
// Revision : 1.0 - initial release
// ============================================================================
module small_div
  import small_div_pkg::*;
#(
  parameter int DIVIDER_VALUE         = 5,
  parameter int DIVIDEND_WIDTH        = 18,
  parameter int THEORETICAL_LUT_WIDTH = 6,
  parameter int REGISTER_IN           = 1,
  parameter int REGISTER_OUT          = 1,
  localparam int DIVIDER_WIDTH        = divider_width(DIVIDER_VALUE)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVIDER_WIDTH-1:0]  remainder
);

  localparam int c_CHUNK  = chunk_width(THEORETICAL_LUT_WIDTH, DIVIDER_WIDTH);
  localparam int c_STAGES = stage_count(DIVIDEND_WIDTH, c_CHUNK);
  localparam int c_PAD    = c_CHUNK * c_STAGES;

  logic [DIVIDEND_WIDTH-1:0] w_div_in;
  logic [c_PAD-1:0]          w_padded;
  logic [c_PAD-1:0]          w_quot_padded;
  logic [DIVIDER_WIDTH-1:0]  w_rem_chain [c_STAGES+1];
  logic [DIVIDEND_WIDTH-1:0] w_quot;
  logic [DIVIDER_WIDTH-1:0]  w_rem;

  // Optional input register bank.
  if (REGISTER_IN != 0) begin : g_reg_in
    logic [DIVIDEND_WIDTH-1:0] r_dividend;
    // Capture the dividend on enabled edges; cleared by reset.
    always_ff @(posedge clock or posedge reset) begin
      if (reset)       r_dividend <= '0;
      else if (enable) r_dividend <= dividend;
    end
    assign w_div_in = r_dividend;
  end else begin : g_no_reg_in
    assign w_div_in = dividend;
  end

  // Zero-extend at the MSB end so the dividend splits into whole chunks.
  always_comb begin
    w_padded                     = '0;
    w_padded[DIVIDEND_WIDTH-1:0] = w_div_in;
  end

  assign w_rem_chain[0] = '0;

  // Most significant chunk is consumed first, as in pencil long division.
  for (genvar i = 0; i < c_STAGES; i++) begin : g_stage
    small_div_stage #(
      .DIVIDER_VALUE (DIVIDER_VALUE),
      .DIVIDER_WIDTH (DIVIDER_WIDTH),
      .CHUNK_WIDTH   (c_CHUNK)
    ) u_stage (
      .i_rem   (w_rem_chain[i]),
      .i_chunk (w_padded[(c_STAGES-1-i)*c_CHUNK +: c_CHUNK]),
      .o_quot  (w_quot_padded[(c_STAGES-1-i)*c_CHUNK +: c_CHUNK]),
      .o_rem   (w_rem_chain[i+1])
    );
  end

  // Quotient bits above the dividend width are always zero after padding.
  if (c_PAD > DIVIDEND_WIDTH) begin : g_pad
    logic w_unused_pad;
    assign w_unused_pad = &{1'b0, w_quot_padded[c_PAD-1:DIVIDEND_WIDTH]};
  end

  assign w_quot = w_quot_padded[DIVIDEND_WIDTH-1:0];
  assign w_rem  = w_rem_chain[c_STAGES];

  // Optional output register bank.
  if (REGISTER_OUT != 0) begin : g_reg_out
    logic [DIVIDEND_WIDTH-1:0] r_quot;
    logic [DIVIDER_WIDTH-1:0]  r_rem;
    // Capture the chain result on enabled edges; cleared by reset.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_quot <= '0;
        r_rem  <= '0;
      end else if (enable) begin
        r_quot <= w_quot;
        r_rem  <= w_rem;
      end
    end
    assign quotient  = r_quot;
    assign remainder = r_rem;
  end else begin : g_no_reg_out
    assign quotient  = w_quot;
    assign remainder = w_rem;
  end

  // In the fully combinational build the control inputs are intentionally idle.
  if (REGISTER_IN == 0 && REGISTER_OUT == 0) begin : g_comb_only
    logic w_unused_ctrl;
    assign w_unused_ctrl = &{1'b0, clock, reset, enable};
  end

endmodule
`default_nettype wire

// File: tb/tb_small_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_small_div
// Purpose  : Self-checking bench for small_div across several configurations
//            sharing one stimulus stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_small_div;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [17:0] dividend;

  // A: D=5 latency 2, B: D=7 latency 1, C: D=11 latency 0,
  // D: D=3 W=7 L=4 latency 2, E: D=3 latency 2.
  logic [17:0] a_quot;  logic [2:0] a_rem;
  logic [17:0] b_quot;  logic [2:0] b_rem;
  logic [17:0] c_quot;  logic [3:0] c_rem;
  logic [6:0]  d_quot;  logic [1:0] d_rem;
  logic [17:0] e_quot;  logic [1:0] e_rem;

  int n_checks  = 0;
  int n_fails   = 0;
  int n_printed = 0;

  logic [17:0] hist[$];

  typedef struct {
    logic [17:0] dividend;
    logic [17:0] q5;
    logic [2:0]  r5;
    logic [17:0] q11;
    logic [3:0]  r11;
  } vec_t;

  vec_t vecs[14];

  always #5 clock = ~clock;

  small_div #(.DIVIDER_VALUE(5), .DIVIDEND_WIDTH(18), .THEORETICAL_LUT_WIDTH(6),
              .REGISTER_IN(1), .REGISTER_OUT(1)) u_dut_a (
    .clock(clock), .reset(reset), .enable(enable), .dividend(dividend),
    .quotient(a_quot), .remainder(a_rem));

  small_div #(.DIVIDER_VALUE(7), .DIVIDEND_WIDTH(18), .THEORETICAL_LUT_WIDTH(6),
              .REGISTER_IN(1), .REGISTER_OUT(0)) u_dut_b (
    .clock(clock), .reset(reset), .enable(enable), .dividend(dividend),
    .quotient(b_quot), .remainder(b_rem));

  small_div #(.DIVIDER_VALUE(11), .DIVIDEND_WIDTH(18), .THEORETICAL_LUT_WIDTH(6),
              .REGISTER_IN(0), .REGISTER_OUT(0)) u_dut_c (
    .clock(clock), .reset(reset), .enable(enable), .dividend(dividend),
    .quotient(c_quot), .remainder(c_rem));

  small_div #(.DIVIDER_VALUE(3), .DIVIDEND_WIDTH(7), .THEORETICAL_LUT_WIDTH(4),
              .REGISTER_IN(1), .REGISTER_OUT(1)) u_dut_d (
    .clock(clock), .reset(reset), .enable(enable), .dividend(dividend[6:0]),
    .quotient(d_quot), .remainder(d_rem));

  small_div #(.DIVIDER_VALUE(3), .DIVIDEND_WIDTH(18), .THEORETICAL_LUT_WIDTH(6),
              .REGISTER_IN(1), .REGISTER_OUT(1)) u_dut_e (
    .clock(clock), .reset(reset), .enable(enable), .dividend(dividend),
    .quotient(e_quot), .remainder(e_rem));

  // History of dividends accepted on enabled edges, newest first.
  always @(posedge clock) begin
    if (!reset && enable) begin
      hist.push_front(dividend);
      if (hist.size() > 4) void'(hist.pop_back());
    end
  end

  // Reset throws away everything in flight.
  always @(posedge reset) hist.delete();

  // Dividend an output of the given latency should currently reflect.
  function automatic logic [31:0] exp_in(input int lat);
    if (lat == 0) return {14'd0, dividend};
    if (hist.size() >= lat) return {14'd0, hist[lat-1]};
    return 32'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      if (n_printed < 40) begin
        $display("FAIL %s: got %0d expected %0d (dividend=%0d, t=%0t)",
                 name, act, exp, dividend, $time);
        n_printed++;
      end
    end
  endtask

  task automatic check_stream();
    logic [31:0] v;
    v = exp_in(2);
    check("a_quot", {14'd0, a_quot}, v / 5);
    check("a_rem",  {29'd0, a_rem},  v % 5);
    check("e_quot", {14'd0, e_quot}, v / 3);
    check("e_rem",  {30'd0, e_rem},  v % 3);
    v = exp_in(1);
    check("b_quot", {14'd0, b_quot}, v / 7);
    check("b_rem",  {29'd0, b_rem},  v % 7);
    v = exp_in(0);
    check("c_quot", {14'd0, c_quot}, v / 11);
    check("c_rem",  {28'd0, c_rem},  v % 11);
    v = exp_in(2) % 128;
    check("d_quot", {25'd0, d_quot}, v / 3);
    check("d_rem",  {30'd0, d_rem},  v % 3);
  endtask

  task automatic stream(input int unsigned start, input int count);
    for (int i = 0; i < count; i++) begin
      dividend = 18'(start + i);
      @(negedge clock);
      check_stream();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{18'd0,      18'd0,     3'd0, 18'd0,     4'd0};
    vecs[1]  = '{18'd4,      18'd0,     3'd4, 18'd0,     4'd4};
    vecs[2]  = '{18'd5,      18'd1,     3'd0, 18'd0,     4'd5};
    vecs[3]  = '{18'd6,      18'd1,     3'd1, 18'd0,     4'd6};
    vecs[4]  = '{18'd10,     18'd2,     3'd0, 18'd0,     4'd10};
    vecs[5]  = '{18'd11,     18'd2,     3'd1, 18'd1,     4'd0};
    vecs[6]  = '{18'd12,     18'd2,     3'd2, 18'd1,     4'd1};
    vecs[7]  = '{18'd100,    18'd20,    3'd0, 18'd9,     4'd1};
    vecs[8]  = '{18'd1000,   18'd200,   3'd0, 18'd90,    4'd10};
    vecs[9]  = '{18'd12345,  18'd2469,  3'd0, 18'd1122,  4'd3};
    vecs[10] = '{18'd65535,  18'd13107, 3'd0, 18'd5957,  4'd8};
    vecs[11] = '{18'd131072, 18'd26214, 3'd2, 18'd11915, 4'd7};
    vecs[12] = '{18'd262140, 18'd52428, 3'd0, 18'd23830, 4'd10};
    vecs[13] = '{18'd262143, 18'd52428, 3'd3, 18'd23831, 4'd2};

    reset    = 1'b1;
    enable   = 1'b1;
    dividend = 18'd12345;

    // Reset state: registered outputs read 0/0 regardless of the input.
    @(negedge clock);
    check_stream();
    @(negedge clock);
    check_stream();
    reset = 1'b0;

    // Directed table: hold each vector long enough for every latency.
    for (int i = 0; i < 14; i++) begin
      dividend = vecs[i].dividend;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("tbl_a_quot", {14'd0, a_quot}, {14'd0, vecs[i].q5});
      check("tbl_a_rem",  {29'd0, a_rem},  {29'd0, vecs[i].r5});
      check("tbl_c_quot", {14'd0, c_quot}, {14'd0, vecs[i].q11});
      check("tbl_c_rem",  {28'd0, c_rem},  {28'd0, vecs[i].r11});
    end

    // Incrementing stream; covers all 128 dividends of the 7-bit config.
    stream(0, 140);

    // Enable gating with a garbage input that must never be sampled.
    enable   = 1'b0;
    dividend = 18'h2AAAA;
    repeat (3) begin
      @(negedge clock);
      check_stream();
    end
    enable = 1'b1;
    stream(140, 20);

    // Top of range and wrap back to zero.
    stream(262100, 60);

    // Asynchronous reset mid-stream, checked before any clock edge.
    #3 reset = 1'b1;
    #1 check_stream();
    @(negedge clock);
    check_stream();
    reset = 1'b0;
    stream(5000, 10);

    // Random dividends across the full range.
    for (int i = 0; i < 1500; i++) begin
      dividend = 18'($urandom_range(0, 262143));
      @(negedge clock);
      check_stream();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
